cpu_run_controller: RTL and testbench

Run/step sequencer for the CPU core. Turns the single board `switch` into CPU control: a short press single-steps one clock-enable cycle, a long press toggles free-running. It also holds the CPU in reset at start-up and after a halt-restart. It sits between the board pins and the CPU's `isReset` and clock-enable inputs, and exports an executed-cycle count for display.

---
 rtl/cpu_run_controller_pkg.sv | 13 +
 rtl/cpu_run_controller_if.sv | 12 +
 rtl/cpu_run_controller_switch_debouncer.sv | 41 ++++
 rtl/cpu_run_controller.sv | 54 +++++
 tb/tb_cpu_run_controller.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_controller_pkg: shared state encoding, register width and timing defaults for the run controller
package cpu_run_controller_pkg;
  localparam int REGISTER_WIDTH = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 1024;
  localparam int DEFAULT_RESET_HOLD_CYCLES = 8;
  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_HALTED = 2'd1,
    S_RUN    = 2'd2,
    S_STEP   = 2'd3
  } run_state_t;
endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: board/CPU-side signals (switch, cpuHalted in; cpuReset, cpuEnable, runState, stepCount out)
interface cpu_run_controller_if;
  import cpu_run_controller_pkg::*;
  logic switch;
  logic cpuHalted;
  logic cpuReset;
  logic cpuEnable;
  logic [1:0] runState;
  logic [REGISTER_WIDTH-1:0] stepCount;
  modport master (output switch, cpuHalted, input cpuReset, cpuEnable, runState, stepCount);
  modport slave (input switch, cpuHalted, output cpuReset, cpuEnable, runState, stepCount);
endinterface

// File: rtl/cpu_run_controller_switch_debouncer.sv
// switch_debouncer: 2-FF sync + debounce of switch_in, classifies presses (out short_press, long_press one-cycle pulses)
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_PRESS_CYCLES = 1024
) (
  input  logic clock,
  input  logic isReset,
  input  logic switch_in,
  output logic short_press,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(LONG_PRESS_CYCLES + 1);
  logic sync1_q, sync2_q, level_q, level_d, settled;
  logic [DW-1:0] db_q, db_d;
  logic [PW-1:0] press_q, press_d;
  always_comb begin
    settled = sync2_q != level_q && db_q == DW'(DEBOUNCE_CYCLES - 1);
    level_d = settled ? sync2_q : level_q;
    db_d = (sync2_q == level_q || settled) ? '0 : db_q + 1'b1;
    press_d = !level_q ? '0 : press_q == PW'(LONG_PRESS_CYCLES) ? press_q : press_q + 1'b1;
    long_press = level_q && press_q == PW'(LONG_PRESS_CYCLES - 1);
    // a release in the very cycle long_press fires still counts as long
    short_press = level_q && !level_d && press_q < PW'(LONG_PRESS_CYCLES - 1);
  end
  always_ff @(posedge clock) begin
    if (isReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      db_q <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= switch_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      db_q <= db_d;
      press_q <= press_d;
    end
  end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/step/reset sequencer (clock, isReset; bus: switch, cpuHalted in; cpuReset, cpuEnable, runState, stepCount out)
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input logic clock,
  input logic isReset,
  cpu_run_controller_if.slave bus
);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  run_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [REGISTER_WIDTH-1:0] count_q, count_d;
  logic short_press, long_press, hold_done, enable;
  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_deb (
    .clock(clock),
    .isReset(isReset),
    .switch_in(bus.switch),
    .short_press(short_press),
    .long_press(long_press)
  );
  assign hold_done = hold_q == HW'(RESET_HOLD_CYCLES - 1);
  assign enable = state_q == S_RUN || state_q == S_STEP;
  always_comb begin
    state_d = state_q == S_RESET ? (hold_done ? S_HALTED : S_RESET)
            : state_q == S_HALTED ? (long_press ? (bus.cpuHalted ? S_RESET : S_RUN)
                                    : (short_press && !bus.cpuHalted) ? S_STEP : S_HALTED)
            : state_q == S_RUN ? ((long_press || bus.cpuHalted) ? S_HALTED : S_RUN)
            : S_HALTED;
    hold_d = (state_q == S_RESET && !hold_done) ? hold_q + 1'b1 : '0;
    count_d = state_d == S_RESET ? '0 : count_q + REGISTER_WIDTH'(enable);
  end
  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q <= S_RESET;
      hold_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      count_q <= count_d;
    end
  end
  assign bus.cpuReset = state_q == S_RESET;
  assign bus.cpuEnable = enable;
  assign bus.runState = state_q;
  assign bus.stepCount = count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed bench for cpu_run_controller with DEBOUNCE=4, LONG=20, HOLD=8, width 8
module tb_cpu_run_controller;
  import cpu_run_controller_pkg::*;
  logic clock = 1'b0;
  logic isReset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int en_cnt = 0;
  bit armed = 1'b0;
  cpu_run_controller_if bus();
  cpu_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20),
    .RESET_HOLD_CYCLES(8)
  ) dut (
    .clock(clock),
    .isReset(isReset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (armed) begin
      if (bus.cpuEnable === 1'b1) en_cnt++;
      compared++;
      assert (!(dut.u_deb.short_press === 1'b1 && dut.u_deb.long_press === 1'b1)) else begin
        mismatched++;
        $error("FAIL press_exclusive: observed short=1 long=1, required at most one");
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask
  initial begin
    bus.switch = 1'b0;
    bus.cpuHalted = 1'b0;
    tick(2);
    isReset = 1'b0;
    armed = 1'b1;
    check("rst_cpuReset", bus.cpuReset, 1);
    check("rst_cpuEnable", bus.cpuEnable, 0);
    check("rst_runState", bus.runState, 0);
    check("rst_stepCount", bus.stepCount, 0);
    tick(7);
    check("hold_last_cpuReset", bus.cpuReset, 1);
    check("hold_last_runState", bus.runState, 0);
    tick();
    check("halted_runState", bus.runState, 1);
    check("halted_cpuReset", bus.cpuReset, 0);
    check("halted_cpuEnable", bus.cpuEnable, 0);
    check("halted_stepCount", bus.stepCount, 0);
    for (int i = 0; i < 10; i++) begin
      bus.switch = ~i[0];
      tick();
    end
    check("bounce_runState", bus.runState, 1);
    check("bounce_no_enable", en_cnt, 0);
    bus.switch = 1'b1;
    tick(10);
    bus.switch = 1'b0;
    tick(6);
    check("step_runState", bus.runState, 3);
    check("step_cpuEnable", bus.cpuEnable, 1);
    tick();
    check("step_after_runState", bus.runState, 1);
    check("step_after_cpuEnable", bus.cpuEnable, 0);
    tick(3);
    check("step_one_pulse", en_cnt, 1);
    check("step_stepCount", bus.stepCount, 1);
    bus.switch = 1'b1;
    tick(25);
    check("long_pre_runState", bus.runState, 1);
    tick();
    check("long_run_runState", bus.runState, 2);
    tick(4);
    check("long_run_stepCount", bus.stepCount, 5);
    bus.switch = 1'b0;
    tick(10);
    check("long_release_runState", bus.runState, 2);
    check("long_release_stepCount", bus.stepCount, 15);
    bus.switch = 1'b1;
    tick(25);
    check("stop_pre_runState", bus.runState, 2);
    tick();
    check("stop_runState", bus.runState, 1);
    check("stop_stepCount", bus.stepCount, 41);
    tick(4);
    bus.switch = 1'b0;
    tick(10);
    check("stop_release_runState", bus.runState, 1);
    check("stop_release_stepCount", bus.stepCount, 41);
    bus.switch = 1'b1;
    tick(30);
    bus.switch = 1'b0;
    tick(10);
    check("halt_run_runState", bus.runState, 2);
    check("halt_run_stepCount", bus.stepCount, 55);
    bus.cpuHalted = 1'b1;
    check("halt_cycle_cpuEnable", bus.cpuEnable, 1);
    tick();
    check("halt_cpuEnable", bus.cpuEnable, 0);
    check("halt_runState", bus.runState, 1);
    check("halt_stepCount", bus.stepCount, 56);
    bus.switch = 1'b1;
    tick(10);
    bus.switch = 1'b0;
    tick(10);
    check("halt_short_ignored_runState", bus.runState, 1);
    check("halt_short_ignored_stepCount", bus.stepCount, 56);
    bus.switch = 1'b1;
    tick(26);
    check("restart_runState", bus.runState, 0);
    check("restart_cpuReset", bus.cpuReset, 1);
    check("restart_stepCount", bus.stepCount, 0);
    tick(4);
    bus.switch = 1'b0;
    bus.cpuHalted = 1'b0;
    tick(10);
    check("restart_halted_runState", bus.runState, 1);
    bus.switch = 1'b1;
    tick(26);
    check("wrap_run_runState", bus.runState, 2);
    check("wrap_run_stepCount", bus.stepCount, 0);
    tick(4);
    bus.switch = 1'b0;
    tick(251);
    check("wrap_max_stepCount", bus.stepCount, 255);
    tick();
    check("wrap_zero_stepCount", bus.stepCount, 0);
    tick(3);
    bus.cpuHalted = 1'b1;
    tick();
    check("wrap_final_stepCount", bus.stepCount, 4);
    check("wrap_final_runState", bus.runState, 1);
    bus.cpuHalted = 1'b0;
    bus.switch = 1'b1;
    tick(10);
    bus.switch = 1'b0;
    tick(6);
    check("midstep_runState", bus.runState, 3);
    isReset = 1'b1;
    tick();
    isReset = 1'b0;
    check("midstep_reset_runState", bus.runState, 0);
    check("midstep_reset_cpuEnable", bus.cpuEnable, 0);
    check("midstep_reset_cpuReset", bus.cpuReset, 1);
    check("midstep_reset_stepCount", bus.stepCount, 0);
    tick(2);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
